// File: rtl/inv_sub_bytes_iter_pkg.sv
// Shared AES constants and FSM encoding for the iterative inverse SubBytes stage.
package inv_sub_bytes_iter_pkg;

  localparam int STATE_W   = 128;
  localparam int NUM_BYTES = 16;
  localparam int CNT_W     = 4;

  typedef logic [STATE_W-1:0] aes_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter value of the final byte group for a given substitution width.
  function automatic logic [CNT_W-1:0] last_group(input int bytes_per_cycle);
    return CNT_W'(NUM_BYTES / bytes_per_cycle - 1);
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// FIPS-197 inverse S-box as a purely combinational 256-entry lookup.
module inv_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [7:0] TBL [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign out_o = TBL[in_i];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES inverse SubBytes: substitutes BYTES_PER_CYCLE state bytes per
// cycle in place in a single 128-bit register, then presents the result.
module inv_sub_bytes_iter
  import inv_sub_bytes_iter_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] isb_data,
  output logic [1:0]         dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; the producer holds valid and payload stable until that edge.

  localparam logic [CNT_W-1:0] LAST_GRP = last_group(BYTES_PER_CYCLE);

  logic [1:0]       st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  aes_state_t       state_q, state_d;

  logic [CNT_W-1:0] grp_base;
  logic [CNT_W-1:0] byte_idx [BYTES_PER_CYCLE];
  logic [7:0]       sb_in    [BYTES_PER_CYCLE];
  logic [7:0]       sb_out   [BYTES_PER_CYCLE];

  // For a 16-byte group the cast yields 0, which matches the counter never leaving 0.
  assign grp_base = cnt_q * CNT_W'(BYTES_PER_CYCLE);

  // Byte n sits at bits [8*(15-n) +: 8]; 15-n is the 4-bit complement of n.
  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_sbox
    assign byte_idx[j] = grp_base + CNT_W'(j);
    assign sb_in[j]    = state_q[{~byte_idx[j], 3'b000} +: 8];

    inv_sbox u_inv_sbox (
      .in_i  (sb_in[j]),
      .out_o (sb_out[j])
    );
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    case (st_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = data;
          cnt_d   = '0;
          st_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
          state_d[{~byte_idx[j], 3'b000} +: 8] = sb_out[j];
        end
        if (cnt_q == LAST_GRP) begin
          cnt_d = '0;
          st_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          st_d = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= ST_IDLE;
      cnt_q   <= '0;
      state_q <= '0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign in_ready    = (st_q == ST_IDLE);
  assign out_valid   = (st_q == ST_DONE);
  assign isb_data    = state_q;
  assign dbg_state_o = st_q;

endmodule
